// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: funct/aluop codes, ALU operation codes,
// and the multiply/divide unit state and operation types.
package mips_pkg;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;

    localparam logic [5:0] FN_SLL    = 6'b000000;
    localparam logic [5:0] FN_SRL    = 6'b000010;
    localparam logic [5:0] FN_SRA    = 6'b000011;
    localparam logic [5:0] FN_ORI    = 6'b001011;
    localparam logic [5:0] FN_MFHI   = 6'b010000;
    localparam logic [5:0] FN_MTHI   = 6'b010001;
    localparam logic [5:0] FN_MFLO   = 6'b010010;
    localparam logic [5:0] FN_MTLO   = 6'b010011;
    localparam logic [5:0] FN_MULT   = 6'b011000;
    localparam logic [5:0] FN_MULTU  = 6'b011001;
    localparam logic [5:0] FN_DIV    = 6'b011010;
    localparam logic [5:0] FN_DIVU   = 6'b011011;
    localparam logic [5:0] FN_ADD    = 6'b100000;
    localparam logic [5:0] FN_SUB    = 6'b100010;
    localparam logic [5:0] FN_AND    = 6'b100100;
    localparam logic [5:0] FN_OR     = 6'b100101;
    localparam logic [5:0] FN_XOR    = 6'b100110;
    localparam logic [5:0] FN_NOR    = 6'b100111;
    localparam logic [5:0] FN_SLT    = 6'b101010;
    localparam logic [5:0] FN_SLTU   = 6'b101011;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_NOR   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLTU  = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b1010;
    localparam logic [3:0] ALU_SRL   = 4'b1100;
    localparam logic [3:0] ALU_SRA   = 4'b1110;

    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} md_state_t;

    // Encoding matches the low two funct bits of mult/multu/div/divu.
    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;

    function automatic md_op_t fn_to_mdop(input logic [5:0] fn);
        return md_op_t'(fn[1:0]);
    endfunction

    function automatic logic is_md_fn(input logic [5:0] fn);
        return (fn[5:2] == 4'b0100) || (fn[5:2] == 4'b0110);
    endfunction

    function automatic logic is_muldiv_fn(input logic [5:0] fn);
        return fn[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative multiply/divide engine: one shift-add or restoring shift-subtract step
// per cycle on operand magnitudes, sign correction applied while in FIX.
module md_iter
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  md_op_t          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic [XLEN-1:0] hi_res,
    output logic [XLEN-1:0] lo_res,
    output logic            done
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    md_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // acc holds the product high half / partial remainder, sh the multiplier / quotient.
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] sh_q, sh_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            is_div_q, is_div_d;
    logic            neg_lo_q, neg_lo_d;
    logic            neg_hi_q, neg_hi_d;
    logic            div0_q, div0_d;

    logic            op_sgn, op_div;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_sh;
    logic [XLEN:0]   div_diff;
    logic            div_ok;

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    assign op_sgn = (op == MD_MULT) || (op == MD_DIV);
    assign op_div = (op == MD_DIV) || (op == MD_DIVU);
    assign a_mag  = (op_sgn && a[XLEN-1]) ? -a : a;
    assign b_mag  = (op_sgn && b[XLEN-1]) ? -b : b;

    assign mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
    assign div_sh   = {acc_q, sh_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign div_ok   = div_sh >= {1'b0, b_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_RUN;
                    cnt_d   = '0;
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = MD_FIX;
            end
            MD_FIX:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        acc_d    = acc_q;
        sh_d     = sh_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        if (state_q == MD_IDLE && start) begin
            acc_d    = '0;
            sh_d     = a_mag;
            b_d      = b_mag;
            is_div_d = op_div;
            neg_lo_d = op_sgn && (a[XLEN-1] ^ b[XLEN-1]);
            neg_hi_d = op_sgn && a[XLEN-1];
            div0_d   = (b == '0);
        end else if (state_q == MD_RUN) begin
            if (is_div_q) begin
                acc_d = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
                sh_d  = {sh_q[XLEN-2:0], div_ok};
            end else begin
                acc_d = mul_sum[XLEN:1];
                sh_d  = {mul_sum[0], sh_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        sh_q     <= sh_d;
        b_q      <= b_d;
        is_div_q <= is_div_d;
        neg_lo_q <= neg_lo_d;
        neg_hi_q <= neg_hi_d;
        div0_q   <= div0_d;
    end

    // A zero divisor yields an all-ones quotient regardless of signs; the remainder
    // then equals |dividend|, which the dividend-sign correction turns back into the dividend.
    assign prod   = {acc_q, sh_q};
    assign prod_s = neg_lo_q ? -prod : prod;
    assign quo_s  = div0_q ? '1 : (neg_lo_q ? -sh_q : sh_q);
    assign rem_s  = neg_hi_q ? -acc_q : acc_q;

    assign hi_res = is_div_q ? rem_s : prod_s[2*XLEN-1:XLEN];
    assign lo_res = is_div_q ? quo_s : prod_s[XLEN-1:0];
    assign done   = (state_q == MD_FIX);
    assign busy   = (state_q != MD_IDLE);

endmodule

// File: rtl/alu_md_ctrl.sv
// MIPS execute-stage ALU control: combinational decode, MDU stall generation,
// HI/LO registers with mthi/mtlo writes and multiply/divide result capture.
module alu_md_ctrl
    import mips_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        aluop,
    input  logic [5:0]        func,
    input  logic [XLEN-1:0]   srca,
    input  logic [XLEN-1:0]   srcb,
    output logic [CTRL_W-1:0] alucontrol,
    output logic              illegal,
    output logic              use_hilo,
    output logic [XLEN-1:0]   hilo_rdata,
    output logic              md_stall,
    output logic              md_busy
);

    logic            rtype;
    logic            is_mdu;
    logic            accept;
    logic            md_start;
    logic            md_done;
    logic [XLEN-1:0] md_hi, md_lo;
    logic [3:0]      ctrl4;

    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    assign rtype = aluop[1];

    always_comb begin
        ctrl4   = ALU_ADD;
        illegal = 1'b0;
        case (aluop)
            AOP_ADD: ctrl4 = (func == FN_ORI) ? ALU_OR : ALU_ADD;
            AOP_SUB: ctrl4 = ALU_SUB;
            default: begin
                case (func)
                    FN_ADD:  ctrl4 = ALU_ADD;
                    FN_SUB:  ctrl4 = ALU_SUB;
                    FN_AND:  ctrl4 = ALU_AND;
                    FN_OR:   ctrl4 = ALU_OR;
                    FN_XOR:  ctrl4 = ALU_XOR;
                    FN_NOR:  ctrl4 = ALU_NOR;
                    FN_SLT:  ctrl4 = ALU_SLT;
                    FN_SLTU: ctrl4 = ALU_SLTU;
                    FN_SLL:  ctrl4 = ALU_SLL;
                    FN_SRL:  ctrl4 = ALU_SRL;
                    FN_SRA:  ctrl4 = ALU_SRA;
                    FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: ctrl4 = ALU_ADD;
                    default: begin
                        ctrl4   = ALU_AND;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign alucontrol = CTRL_W'(ctrl4);
    assign use_hilo   = rtype && (func == FN_MFHI || func == FN_MFLO);
    assign hilo_rdata = (func == FN_MFHI) ? hi_q : lo_q;

    // Any HI/LO access waits for the MDU to drain, so reads always see the final result.
    assign is_mdu   = rtype && is_md_fn(func);
    assign md_stall = en && is_mdu && md_busy;
    assign accept   = en && !md_stall;
    assign md_start = accept && rtype && is_muldiv_fn(func);

    md_iter #(
        .XLEN (XLEN)
    ) u_md_iter (
        .clk    (clk),
        .rst_n  (reset),
        .start  (md_start),
        .op     (fn_to_mdop(func)),
        .a      (srca),
        .b      (srcb),
        .busy   (md_busy),
        .hi_res (md_hi),
        .lo_res (md_lo),
        .done   (md_done)
    );

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (md_done) begin
            hi_d = md_hi;
            lo_d = md_lo;
        end
        if (accept && rtype && func == FN_MTHI) hi_d = srca;
        if (accept && rtype && func == FN_MTLO) lo_d = srca;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule
